// File: rtl/msrh_ldq_sched_if.sv
// Signal bundle between the LDQ scheduler and its surroundings (dispatch,
// per-entry state machines, LSU pipes). The scheduler takes the slave side.
interface msrh_ldq_sched_if #(
    parameter int ENTRY_NUM  = 16,
    parameter int PIPE_NUM   = 2,
    parameter int DISP_WIDTH = 2,
    parameter int IDX_W      = $clog2(ENTRY_NUM)
);
    logic [DISP_WIDTH-1:0]                i_disp_valid;
    logic                                 o_disp_ready;
    logic [DISP_WIDTH-1:0][IDX_W-1:0]     o_disp_index;
    logic [ENTRY_NUM-1:0]                 o_disp_alloc_oh;
    logic [ENTRY_NUM-1:0]                 i_entry_ready;
    logic [ENTRY_NUM-1:0][PIPE_NUM-1:0]   i_entry_pipe_sel;
    logic [PIPE_NUM-1:0]                  i_pipe_stall;
    logic [PIPE_NUM-1:0]                  o_pick_valid;
    logic [PIPE_NUM-1:0][IDX_W-1:0]       o_pick_index;
    logic [ENTRY_NUM-1:0]                 o_entry_picked;
    logic [ENTRY_NUM-1:0]                 i_entry_clr_wait;
    logic [ENTRY_NUM-1:0]                 o_outptr_oh;
    logic [IDX_W:0]                       o_count;
    logic                                 o_full;
    logic                                 o_empty;

    modport master (
        output i_disp_valid, i_entry_ready, i_entry_pipe_sel, i_pipe_stall, i_entry_clr_wait,
        input  o_disp_ready, o_disp_index, o_disp_alloc_oh, o_pick_valid, o_pick_index,
               o_entry_picked, o_outptr_oh, o_count, o_full, o_empty
    );

    modport slave (
        input  i_disp_valid, i_entry_ready, i_entry_pipe_sel, i_pipe_stall, i_entry_clr_wait,
        output o_disp_ready, o_disp_index, o_disp_alloc_oh, o_pick_valid, o_pick_index,
               o_entry_picked, o_outptr_oh, o_count, o_full, o_empty
    );
endinterface

// File: rtl/msrh_ldq_sched.sv
// Load-queue allocation/issue scheduler: circular in/out pointers with an
// occupancy count, oldest-first pick per LSU pipe, in-order release.
module msrh_ldq_sched #(
    parameter int ENTRY_NUM  = 16,
    parameter int PIPE_NUM   = 2,
    parameter int DISP_WIDTH = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    msrh_ldq_sched_if.slave   bus
);
    localparam int IDX_W = $clog2(ENTRY_NUM);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(ENTRY_NUM - DISP_WIDTH);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(ENTRY_NUM);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    logic [IDX_W-1:0] inptr_q, inptr_d;
    logic [IDX_W-1:0] outptr_q, outptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic                            disp_ready;
    logic [CNT_W-1:0]                acc_cnt;
    logic [IDX_W-1:0]                lane_idx;
    logic [DISP_WIDTH-1:0][IDX_W-1:0] disp_index;
    logic [ENTRY_NUM-1:0]            alloc_oh;
    logic [IDX_W-1:0]                scan_idx;
    logic [PIPE_NUM-1:0]             pick_valid;
    logic [PIPE_NUM-1:0][IDX_W-1:0]  pick_index;
    logic [ENTRY_NUM-1:0]            entry_picked;
    logic                            release_en;
    logic [ENTRY_NUM-1:0]            outptr_oh;

    // Valid lanes are packed onto consecutive slots starting at the in-pointer.
    always_comb begin
        disp_ready = (count_q <= READY_MAX);
        acc_cnt    = '0;
        lane_idx   = '0;
        disp_index = '0;
        alloc_oh   = '0;
        for (int k = 0; k < DISP_WIDTH; k++) begin
            if (bus.i_disp_valid[k] && disp_ready) begin
                lane_idx      = inptr_q + acc_cnt[IDX_W-1:0];
                disp_index[k] = lane_idx;
                alloc_oh[lane_idx] = 1'b1;
                acc_cnt       = acc_cnt + CNT_ONE;
            end
        end
    end

    // Scan from youngest to oldest age so the last hit is the oldest candidate.
    always_comb begin
        scan_idx     = '0;
        pick_valid   = '0;
        pick_index   = '0;
        entry_picked = '0;
        for (int p = 0; p < PIPE_NUM; p++) begin
            for (int a = ENTRY_NUM - 1; a >= 0; a--) begin
                scan_idx = outptr_q + IDX_W'(a);
                if (bus.i_entry_ready[scan_idx] && bus.i_entry_pipe_sel[scan_idx][p] &&
                    !bus.i_pipe_stall[p]) begin
                    pick_valid[p] = 1'b1;
                    pick_index[p] = scan_idx;
                end
            end
            if (pick_valid[p]) begin
                entry_picked[pick_index[p]] = 1'b1;
            end
        end
    end

    always_comb begin
        release_en = (count_q != '0) && bus.i_entry_clr_wait[outptr_q];
        outptr_oh  = '0;
        outptr_d   = outptr_q;
        if (release_en) begin
            outptr_oh[outptr_q] = 1'b1;
            outptr_d            = outptr_q + IDX_ONE;
        end
        inptr_d = inptr_q + acc_cnt[IDX_W-1:0];
        count_d = count_q + acc_cnt - CNT_W'(release_en);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            inptr_q  <= '0;
            outptr_q <= '0;
            count_q  <= '0;
        end else begin
            inptr_q  <= inptr_d;
            outptr_q <= outptr_d;
            count_q  <= count_d;
        end
    end

    assign bus.o_disp_ready    = disp_ready;
    assign bus.o_disp_index    = disp_index;
    assign bus.o_disp_alloc_oh = alloc_oh;
    assign bus.o_pick_valid    = pick_valid;
    assign bus.o_pick_index    = pick_index;
    assign bus.o_entry_picked  = entry_picked;
    assign bus.o_outptr_oh     = outptr_oh;
    assign bus.o_count         = count_q;
    assign bus.o_full          = (count_q == FULL_CNT);
    assign bus.o_empty         = (count_q == '0);
endmodule
